// File: rtl/codec_intf.sv
// rtl/codec_intf.sv - I2S master for the CS4272: clock generation, codec reset, 16-bit sample RX/TX
module codec_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SDout,
    input  logic [15:0] lft_out,
    input  logic [15:0] rht_out,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        RSTn,
    output logic        SDin,
    output logic [15:0] lft_in,
    output logic [15:0] rht_in,
    output logic        valid
);

    logic [9:0]  cnt_q, cnt_d;
    logic        rstn_q, rstn_d;
    logic        sdin_q, sdin_d;
    logic        valid_q, valid_d;
    logic [15:0] lft_in_q, lft_in_d;
    logic [15:0] rht_in_q, rht_in_d;
    logic [15:0] rx_l_q, rx_l_d;
    logic [15:0] rx_r_q, rx_r_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic [15:0] tx_l_q, tx_l_d;
    logic [15:0] tx_r_q, tx_r_d;
    logic [4:0]  rx_slot;
    logic [4:0]  tx_slot;
    logic        rx_bit;
    logic        tx_edge;

    always_comb begin
        cnt_d    = cnt_q + 10'd1;
        rstn_d   = rstn_q | (cnt_q == 10'h3FF);
        sdin_d   = sdin_q;
        lft_in_d = lft_in_q;
        rht_in_d = rht_in_q;
        rx_l_d   = rx_l_q;
        rx_r_d   = rx_r_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        tx_l_d   = tx_l_q;
        tx_r_d   = tx_r_q;

        // Sample one clk before SCLK rises, mid-bit; only the top 16 of 24 bits are kept.
        rx_slot = cnt_q[8:4];
        rx_bit  = (cnt_q[3:0] == 4'd7) && (rx_slot >= 5'd1) && (rx_slot <= 5'd16);
        if (rx_bit) begin
            if (cnt_q[9]) begin
                rx_r_d = {rx_r_q[14:0], SDout};
            end else begin
                rx_l_d = {rx_l_q[14:0], SDout};
            end
        end

        valid_d = rstn_q && (cnt_q == 10'h307);
        if (valid_d) begin
            lft_in_d = rx_l_q;
            rht_in_d = rx_r_d;
        end

        if (valid_q) begin
            hold_l_d = lft_out;
            hold_r_d = rht_out;
        end

        // SDin changes as SCLK falls; tx_slot is the slot being entered.
        tx_slot = cnt_d[8:4];
        tx_edge = (cnt_q[3:0] == 4'hF);
        if (tx_edge) begin
            sdin_d = 1'b0;
            if (tx_slot == 5'd0) begin
                if (cnt_d[9]) begin
                    tx_r_d = hold_r_q;
                end else begin
                    tx_l_d = hold_l_q;
                end
            end else if (tx_slot <= 5'd16) begin
                if (cnt_d[9]) begin
                    sdin_d = tx_r_q[15];
                    tx_r_d = {tx_r_q[14:0], 1'b0};
                end else begin
                    sdin_d = tx_l_q[15];
                    tx_l_d = {tx_l_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 10'd0;
            rstn_q   <= 1'b0;
            sdin_q   <= 1'b0;
            valid_q  <= 1'b0;
            lft_in_q <= 16'd0;
            rht_in_q <= 16'd0;
            rx_l_q   <= 16'd0;
            rx_r_q   <= 16'd0;
            hold_l_q <= 16'd0;
            hold_r_q <= 16'd0;
            tx_l_q   <= 16'd0;
            tx_r_q   <= 16'd0;
        end else begin
            cnt_q    <= cnt_d;
            rstn_q   <= rstn_d;
            sdin_q   <= sdin_d;
            valid_q  <= valid_d;
            lft_in_q <= lft_in_d;
            rht_in_q <= rht_in_d;
            rx_l_q   <= rx_l_d;
            rx_r_q   <= rx_r_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            tx_l_q   <= tx_l_d;
            tx_r_q   <= tx_r_d;
        end
    end

    assign MCLK   = cnt_q[1];
    assign SCLK   = cnt_q[3];
    assign LRCLK  = cnt_q[9];
    assign RSTn   = rstn_q;
    assign SDin   = sdin_q;
    assign valid  = valid_q;
    assign lft_in = lft_in_q;
    assign rht_in = rht_in_q;

endmodule

// File: tb/tb_codec_intf.sv
// tb/tb_codec_intf.sv - randomized bench for codec_intf against a frame-level reference model
`timescale 1ns/1ps
module tb_codec_intf;

    logic        clk;
    logic        rst_n;
    logic        sd_codec;
    logic        lb;
    logic        sdout_w;
    logic [15:0] lft_out, rht_out;
    logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
    logic [15:0] lft_in, rht_in;

    int k;
    int total, passes;
    int nv, first_v;
    bit run;
    logic [31:0] cap_l, cap_r;

    logic [15:0] txw [2][16];
    logic [23:0] cw  [2][16];
    bit          frc_en [16];
    logic [15:0] frc_l [16];
    logic [15:0] frc_r [16];
    bit          fix_en [16];
    logic [23:0] fix_l [16];
    logic [23:0] fix_r [16];
    logic [15:0] lb_vals [4];

    assign sdout_w = lb ? SDin : sd_codec;

    codec_intf dut (
        .clk(clk), .rst_n(rst_n), .SDout(sdout_w),
        .lft_out(lft_out), .rht_out(rht_out),
        .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .RSTn(RSTn), .SDin(SDin),
        .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) passes = passes + 1;
        else $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    endtask

    // Sample received at the valid of frame g.
    function automatic logic [15:0] exp_rx(input int ch, input int g);
        if (lb) return (g >= 2) ? txw[ch][g-1] : 16'h0000;
        return cw[ch][g][23:8];
    endfunction

    // k = clk edges since rst_n release; everything follows from frame f and phase p.
    function automatic logic [37:0] model_out(input int kk, input logic rn);
        int p, f, g, s, h;
        logic [15:0] el, er, d;
        logic esd, ersn, evl;
        if (!rn) return '0;
        p = kk % 1024;
        f = kk / 1024;
        s = (p % 512) / 16;
        h = p / 512;
        g = (p >= 776) ? f : f - 1;
        el = (g >= 1) ? exp_rx(0, g) : 16'h0000;
        er = (g >= 1) ? exp_rx(1, g) : 16'h0000;
        d = (f >= 2) ? txw[h][f-1] : 16'h0000;
        esd = (s >= 1 && s <= 16) ? d[16-s] : 1'b0;
        ersn = (kk >= 1024);
        evl = ersn && (p == 776);
        return {(p / 2) % 2 == 1, (p / 8) % 2 == 1, h == 1, ersn, esd, evl, el, er};
    endfunction

    always @(negedge clk) begin
        if (run) chk("cycle", {MCLK, SCLK, LRCLK, RSTn, SDin, valid, lft_in, rht_in}, model_out(k, rst_n));
    end

    task automatic drive();
        int p, f, s, h;
        logic [31:0] r;
        p = k % 1024;
        f = k / 1024;
        s = (p % 512) / 16;
        h = p / 512;
        r = $urandom;
        lft_out = r[15:0];
        rht_out = r[31:16];
        if (k >= 1024 && p == 776) begin
            if (frc_en[f]) begin
                lft_out = frc_l[f];
                rht_out = frc_r[f];
            end
            txw[0][f] = lft_out;
            txw[1][f] = rht_out;
        end
        if (p == 0) begin
            r = $urandom;
            cw[0][f] = fix_en[f] ? fix_l[f] : r[23:0];
            r = $urandom;
            cw[1][f] = fix_en[f] ? fix_r[f] : r[23:0];
        end
        if (p % 16 == 0) begin
            r = $urandom;
            sd_codec = (s >= 1 && s <= 24) ? cw[h][f][24-s] : r[0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) k = k + 1;
        #1;
        if (rst_n) begin
            if (valid) begin
                nv = nv + 1;
                if (first_v < 0) first_v = k;
            end
            if (k / 1024 == 2 && k % 16 == 8) begin
                if ((k % 1024) < 512) cap_l = {cap_l[30:0], SDin};
                else cap_r = {cap_r[30:0], SDin};
            end
        end
        drive();
    endtask

    task automatic run_until(input int kend);
        while (k < kend) step();
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        k = 0;
        nv = 0;
        first_v = -1;
        for (int i = 0; i < 16; i++) begin
            txw[0][i] = '0; txw[1][i] = '0;
            cw[0][i] = '0;  cw[1][i] = '0;
            frc_en[i] = 0;  fix_en[i] = 0;
        end
        repeat (4) step();
        run = 1;
        chk("reset", {MCLK, SCLK, LRCLK, RSTn, SDin, valid, lft_in, rht_in}, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; passes = 0; run = 0; lb = 0;
        rst_n = 1'b0; sd_codec = 1'b0; lft_out = '0; rht_out = '0;
        cap_l = '0; cap_r = '0;
        lb_vals[0] = 16'h0000; lb_vals[1] = 16'h7FFF;
        lb_vals[2] = 16'h8000; lb_vals[3] = 16'hA5A5;

        // Codec-driven receive, fixed transmit pattern, cadence.
        reset_seq();
        fix_en[2] = 1; fix_l[2] = 24'hFEDCBA; fix_r[2] = 24'h123456;
        frc_en[1] = 1; frc_l[1] = 16'h8001; frc_r[1] = 16'h7FFE;
        run_until(1023);
        chk("rstn_low", RSTn, 1'b0);
        step();
        chk("rstn_high", RSTn, 1'b1);
        run_until(2 * 1024 + 776);
        chk("rx_left", lft_in, 16'hFEDC);
        chk("rx_right", rht_in, 16'h1234);
        run_until(3 * 1024);
        chk("tx_left", cap_l, {1'b0, 24'h800100, 7'h00});
        chk("tx_right", cap_r, {1'b0, 24'h7FFE00, 7'h00});
        run_until(10 * 1024);
        chk("first_valid", first_v, 1800);
        chk("valid_count", nv, 9);

        // Loopback.
        lb = 1;
        reset_seq();
        for (int i = 0; i < 4; i++) begin
            frc_en[i+1] = 1; frc_l[i+1] = lb_vals[i]; frc_r[i+1] = lb_vals[i];
        end
        for (int i = 0; i < 4; i++) begin
            run_until(1024 * (i + 2) + 776);
            chk("loop_left", lft_in, lb_vals[i]);
            chk("loop_right", rht_in, lb_vals[i]);
        end
        run_until(7 * 1024);

        // Reset in the middle of an active frame.
        lb = 0;
        reset_seq();
        run_until(2 * 1024 + 12'h150);
        rst_n = 1'b0;
        k = 0;
        #1;
        chk("mid_reset", {MCLK, SCLK, LRCLK, RSTn, SDin, valid, lft_in, rht_in}, 64'd0);
        reset_seq();
        run_until(2 * 1024);
        chk("restart_first_valid", first_v, 1800);
        chk("restart_valid_count", nv, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
